channel_scanner: RTL and testbench
==================================

CHANNEL_SCANNER -- requirements
Module: channel_scanner

Interface
REQ-001 The block SHALL have parameter DWELL_W, default 4, giving the width of the dwell input and internal dwell counter.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: a request to begin scanning, sampled only in IDLE.
REQ-005 The block SHALL have port stop, input, 1 bit: a request to abort scanning, sampled in every state.
REQ-006 The block SHALL have port mask, input, 8 bits: the enabled channels, where bit i=1 enables channel i.
REQ-007 The block SHALL have port dwell, input, DWELL_W bits: the extra cycles each channel is held, so each channel is held dwell+1 cycles.
REQ-008 The block SHALL have port out, output, 3 bits: the current channel code, which drives the 3-to-8 one-hot decoder input directly.
REQ-009 The block SHALL have port valid, output, 1 bit: high while out names an active scanned channel.
REQ-010 The block SHALL have port busy, output, 1 bit: high in SCAN.
REQ-011 The block SHALL have port wrap, output, 1 bit: a one-cycle pulse when the scan wraps to a channel index at or below the previous one.
REQ-012 The block SHALL have port passes, output, 8 bits: the count of completed wraps since the last start, saturating at 255.

Function
REQ-013 The FSM SHALL have exactly two states: IDLE and SCAN.
REQ-014 In IDLE, start=1, stop=0 and mask!=0 SHALL cause, at the next edge: SCAN; out=lowest set bit index of mask; valid=1; busy=1; dwell counter loaded with dwell; passes=0.
REQ-015 In IDLE, start=1 with mask==0 SHALL be ignored (remain IDLE, all outputs unchanged).
REQ-016 In IDLE, start=1 with stop=1 in the same cycle SHALL be ignored; stop has priority.
REQ-017 In SCAN with counter!=0 and stop=0, the counter SHALL decrement by 1 and out SHALL hold.
REQ-018 In SCAN with counter==0 and stop=0, the advance SHALL select the next set bit of the current mask, searching circularly from out+1 modulo 8; out takes that index and the counter reloads from the current dwell.
REQ-019 An advance whose new index is less than or equal to the old index SHALL assert wrap for exactly the cycle in which the new out is first presented, and passes SHALL increment (saturating at 255) on the same edge.
REQ-020 If exactly one mask bit is set at an advance, the block SHALL re-select the same index and treat it as a wrap.
REQ-021 If mask==0 at an advance, the block SHALL enter IDLE with valid=0, busy=0 and wrap=0, and out SHALL hold.
REQ-022 Mask changes between advances SHALL NOT affect the current channel, and dwell changes SHALL take effect only at the next load.
REQ-023 stop=1 in SCAN SHALL cause, at the next edge: IDLE, valid=0, busy=0, wrap=0; out and passes hold; stop overrides a coincident advance.
REQ-024 start in SCAN SHALL be ignored.
REQ-025 out, valid, busy, wrap and passes SHALL be registered, with no combinational path from any input to any output.
REQ-026 Latency SHALL be one cycle from start sampled to the first valid code, and one cycle from stop sampled to valid=0.

Reset
REQ-027 Asserting rst SHALL immediately, independent of clk, force: IDLE, out=3'b000, valid=0, busy=0, wrap=0, passes=0, dwell counter=0.
REQ-028 rst asserted mid-scan SHALL abandon the scan with no further wrap pulse; after release the block SHALL wait in IDLE for a new start.
REQ-029 The first edge after rst deasserts SHALL behave as a normal IDLE cycle.

Verification
REQ-030 Full scan: mask=8'hFF, dwell=0, start pulse -> out=0,1,...,7,0 on consecutive cycles; wrap high only with the second out=0; passes=1.
REQ-031 Sparse mask with dwell: mask=8'b1010_0100, dwell=2 -> out=2,2,2,5,5,5,7,7,7,2 ...; wrap coincides with the return to 2.
REQ-032 Single channel: mask=8'h10, dwell=1 -> out=4 throughout; wrap pulses every 2 cycles; passes counts 1,2,3 ...
REQ-033 Edge cases: mask=0 with start -> stays IDLE, valid=0; mask cleared mid-scan -> IDLE at the next advance; start+stop in the same cycle -> stays IDLE.
REQ-034 Abort: stop asserted on the same cycle as an advance (counter==0) -> next cycle valid=0, out unchanged, no wrap.
REQ-035 Async reset: rst asserted between edges while out=5, passes=3 -> out=0, passes=0, valid=0 immediately; passes saturates at 255 after more than 255 wraps with dwell=0, mask=8'h01.

Source files
------------

// File: rtl/channel_scanner.sv
// Round-robin channel scanner: walks the set bits of an 8-bit mask, holding each
// enabled channel dwell+1 cycles, with wrap pulse and saturating pass counter.
module channel_scanner #(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [7:0]         mask,
  input  logic [DWELL_W-1:0] dwell,
  output logic [2:0]         out,
  output logic               valid,
  output logic               busy,
  output logic               wrap,
  output logic [7:0]         passes
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SCAN = 1'b1;

  logic [0:0]         state_r;
  logic [DWELL_W-1:0] cnt_r;
  logic [2:0]         first_s;
  logic [2:0]         next_s;
  logic               wraps_s;

  function automatic logic [2:0] lowest_set(input logic [7:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (m[k]) begin
        r = 3'(k);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Circular search from cur+1; the eighth probe lands back on cur itself,
  // which is how a single-bit mask re-selects its own channel.
  function automatic logic [2:0] next_set(input logic [7:0] m, input logic [2:0] cur);
    logic [2:0] r;
    logic [2:0] idx;
    logic       found;
    r     = cur;
    found = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      idx = cur + 3'(k);
      if (!found && m[idx]) begin
        r     = idx;
        found = 1'b1;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  // Candidate channel indices for the start and advance paths.
  always_comb begin
    first_s = lowest_set(mask);
    next_s  = next_set(mask, out);
    wraps_s = (next_s <= out);
  end

  // Scan state machine; all outputs are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      out     <= 3'd0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      wrap    <= 1'b0;
      passes  <= 8'd0;
    end else begin
      case (state_r)
        IDLE: begin
          wrap <= 1'b0;
          if (start && !stop && (mask != 8'd0)) begin
            state_r <= SCAN;
            out     <= first_s;
            valid   <= 1'b1;
            busy    <= 1'b1;
            cnt_r   <= dwell;
            passes  <= 8'd0;
          end
        end
        SCAN: begin
          if (stop) begin
            state_r <= IDLE;
            valid   <= 1'b0;
            busy    <= 1'b0;
            wrap    <= 1'b0;
          end else if (cnt_r != '0) begin
            cnt_r <= cnt_r - {{(DWELL_W-1){1'b0}}, 1'b1};
            wrap  <= 1'b0;
          end else if (mask == 8'd0) begin
            state_r <= IDLE;
            valid   <= 1'b0;
            busy    <= 1'b0;
            wrap    <= 1'b0;
          end else begin
            out   <= next_s;
            cnt_r <= dwell;
            wrap  <= wraps_s;
            if (wraps_s && (passes != 8'd255)) begin
              passes <= passes + 8'd1;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          valid   <= 1'b0;
          busy    <= 1'b0;
          wrap    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_channel_scanner.sv
// Directed, table-driven bench for channel_scanner with hand-written sequences
// for asynchronous reset and pass-counter saturation.
module tb_channel_scanner;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic [7:0] mask;
  logic [3:0] dwell;
  logic [2:0] out;
  logic       valid;
  logic       busy;
  logic       wrap;
  logic [7:0] passes;

  int n_cmp;
  int n_bad;

  typedef struct {
    logic       st;
    logic       sp;
    logic [7:0] m;
    logic [3:0] d;
    logic [2:0] e_out;
    logic       e_valid;
    logic       e_busy;
    logic       e_wrap;
    logic [7:0] e_passes;
  } vec_t;

  vec_t vecs[$];

  channel_scanner #(.DWELL_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .mask(mask), .dwell(dwell),
    .out(out), .valid(valid), .busy(busy), .wrap(wrap), .passes(passes)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] o, input logic v,
                         input logic b, input logic w, input logic [7:0] p);
    chk({tag, ".out"},    32'(out),    32'(o));
    chk({tag, ".valid"},  32'(valid),  32'(v));
    chk({tag, ".busy"},   32'(busy),   32'(b));
    chk({tag, ".wrap"},   32'(wrap),   32'(w));
    chk({tag, ".passes"}, 32'(passes), 32'(p));
  endtask

  function automatic void add(input logic st, input logic sp, input logic [7:0] m,
                              input logic [3:0] d, input logic [2:0] o, input logic v,
                              input logic b, input logic w, input logic [7:0] p);
    vec_t x;
    x.st = st; x.sp = sp; x.m = m; x.d = d;
    x.e_out = o; x.e_valid = v; x.e_busy = b; x.e_wrap = w; x.e_passes = p;
    vecs.push_back(x);
  endfunction

  // Inputs are driven at the falling edge, outputs checked at the next falling edge.
  task automatic step(input logic st, input logic sp, input logic [7:0] m, input logic [3:0] d);
    start = st; stop = sp; mask = m; dwell = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1; start = 1'b0; stop = 1'b0; mask = 8'd0; dwell = 4'd0;

    // Full scan, mask FF dwell 0
    add(1'b0, 1'b0, 8'hFF, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    add(1'b1, 1'b0, 8'hFF, 4'd0, 3'd0, 1'b1, 1'b1, 1'b0, 8'd0);
    for (int i = 1; i <= 7; i++)
      add(1'b0, 1'b0, 8'hFF, 4'd0, 3'(i), 1'b1, 1'b1, 1'b0, 8'd0);
    add(1'b0, 1'b0, 8'hFF, 4'd0, 3'd0, 1'b1, 1'b1, 1'b1, 8'd1);
    add(1'b0, 1'b0, 8'hFF, 4'd0, 3'd1, 1'b1, 1'b1, 1'b0, 8'd1);
    // Stop, then start+stop together, then start with empty mask
    add(1'b0, 1'b1, 8'hFF, 4'd0, 3'd1, 1'b0, 1'b0, 1'b0, 8'd1);
    add(1'b1, 1'b1, 8'hFF, 4'd0, 3'd1, 1'b0, 1'b0, 1'b0, 8'd1);
    add(1'b1, 1'b0, 8'h00, 4'd0, 3'd1, 1'b0, 1'b0, 1'b0, 8'd1);
    // Sparse mask A4 with dwell 2
    add(1'b1, 1'b0, 8'hA4, 4'd2, 3'd2, 1'b1, 1'b1, 1'b0, 8'd0);
    add(1'b0, 1'b0, 8'hA4, 4'd2, 3'd2, 1'b1, 1'b1, 1'b0, 8'd0);
    add(1'b0, 1'b0, 8'hA4, 4'd2, 3'd2, 1'b1, 1'b1, 1'b0, 8'd0);
    add(1'b0, 1'b0, 8'hA4, 4'd2, 3'd5, 1'b1, 1'b1, 1'b0, 8'd0);
    add(1'b0, 1'b0, 8'hA4, 4'd2, 3'd5, 1'b1, 1'b1, 1'b0, 8'd0);
    add(1'b0, 1'b0, 8'hA4, 4'd2, 3'd5, 1'b1, 1'b1, 1'b0, 8'd0);
    add(1'b0, 1'b0, 8'hA4, 4'd2, 3'd7, 1'b1, 1'b1, 1'b0, 8'd0);
    add(1'b0, 1'b0, 8'hA4, 4'd2, 3'd7, 1'b1, 1'b1, 1'b0, 8'd0);
    add(1'b0, 1'b0, 8'hA4, 4'd2, 3'd7, 1'b1, 1'b1, 1'b0, 8'd0);
    add(1'b0, 1'b0, 8'hA4, 4'd2, 3'd2, 1'b1, 1'b1, 1'b1, 8'd1);
    add(1'b0, 1'b0, 8'hA4, 4'd2, 3'd2, 1'b1, 1'b1, 1'b0, 8'd1);
    // Start while scanning is ignored
    add(1'b1, 1'b0, 8'hA4, 4'd2, 3'd2, 1'b1, 1'b1, 1'b0, 8'd1);
    add(1'b0, 1'b0, 8'hA4, 4'd2, 3'd5, 1'b1, 1'b1, 1'b0, 8'd1);
    // Dwell change applies only at the next load
    add(1'b0, 1'b0, 8'hA4, 4'd0, 3'd5, 1'b1, 1'b1, 1'b0, 8'd1);
    add(1'b0, 1'b0, 8'hA4, 4'd0, 3'd5, 1'b1, 1'b1, 1'b0, 8'd1);
    add(1'b0, 1'b0, 8'hA4, 4'd0, 3'd7, 1'b1, 1'b1, 1'b0, 8'd1);
    add(1'b0, 1'b0, 8'hA4, 4'd0, 3'd2, 1'b1, 1'b1, 1'b1, 8'd2);
    // Mask cleared: IDLE at the advance, out holds
    add(1'b0, 1'b0, 8'h00, 4'd0, 3'd2, 1'b0, 1'b0, 1'b0, 8'd2);
    // Single channel, mask 10 dwell 1
    add(1'b1, 1'b0, 8'h10, 4'd1, 3'd4, 1'b1, 1'b1, 1'b0, 8'd0);
    add(1'b0, 1'b0, 8'h10, 4'd1, 3'd4, 1'b1, 1'b1, 1'b0, 8'd0);
    add(1'b0, 1'b0, 8'h10, 4'd1, 3'd4, 1'b1, 1'b1, 1'b1, 8'd1);
    add(1'b0, 1'b0, 8'h10, 4'd1, 3'd4, 1'b1, 1'b1, 1'b0, 8'd1);
    add(1'b0, 1'b0, 8'h10, 4'd1, 3'd4, 1'b1, 1'b1, 1'b1, 8'd2);
    add(1'b0, 1'b0, 8'h10, 4'd1, 3'd4, 1'b1, 1'b1, 1'b0, 8'd2);
    add(1'b0, 1'b0, 8'h10, 4'd1, 3'd4, 1'b1, 1'b1, 1'b1, 8'd3);
    add(1'b0, 1'b0, 8'h10, 4'd1, 3'd4, 1'b1, 1'b1, 1'b0, 8'd3);
    // Stop coincident with an advance: no wrap, out holds
    add(1'b0, 1'b1, 8'h10, 4'd1, 3'd4, 1'b0, 1'b0, 1'b0, 8'd3);
    add(1'b0, 1'b0, 8'h10, 4'd1, 3'd4, 1'b0, 1'b0, 1'b0, 8'd3);

    #12;
    chk_all("reset", 3'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].st, vecs[i].sp, vecs[i].m, vecs[i].d);
      chk_all($sformatf("vec%0d", i), vecs[i].e_out, vecs[i].e_valid,
              vecs[i].e_busy, vecs[i].e_wrap, vecs[i].e_passes);
    end

    // Async reset mid-scan with out=5, passes=3 (mask 24, dwell 0)
    step(1'b1, 1'b0, 8'h24, 4'd0);
    chk_all("ar_start", 3'd2, 1'b1, 1'b1, 1'b0, 8'd0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 8'h24, 4'd0);
    chk_all("ar_pre", 3'd5, 1'b1, 1'b1, 1'b0, 8'd3);
    #2 rst = 1'b1;
    #1 chk_all("ar_now", 3'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 1'b0, 8'h24, 4'd0);
    chk_all("ar_idle", 3'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    step(1'b1, 1'b0, 8'h24, 4'd0);
    chk_all("ar_restart", 3'd2, 1'b1, 1'b1, 1'b0, 8'd0);

    // Saturation: mask 01 dwell 0 wraps every cycle
    step(1'b0, 1'b1, 8'h01, 4'd0);
    step(1'b1, 1'b0, 8'h01, 4'd0);
    chk_all("sat_start", 3'd0, 1'b1, 1'b1, 1'b0, 8'd0);
    for (int i = 1; i <= 270; i++) begin
      step(1'b0, 1'b0, 8'h01, 4'd0);
      chk($sformatf("sat%0d.passes", i), 32'(passes), (i > 255) ? 32'd255 : 32'(i));
      chk($sformatf("sat%0d.wrap", i), 32'(wrap), 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
